// File: rtl/set_bit_scanner_pkg.sv
// Shared types and helpers for the set-bit scanner and its priority encoder.
// The index-width helper sizes index buses consistently across callers.
package scan_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Never narrower than one bit, so a WIDTH=1 caller still gets a legal bus.
  function automatic int idx_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/set_bit_scanner_prio_enc.sv
// Combinational priority encoder: index of the lowest (or highest) set bit,
// plus any-set and at-most-one-set flags. Generalises the old 8-bit encoder.
module prio_enc
  import scan_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b1,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             single
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Walk away from the priority end so the last hit is the winner.
  always_comb begin
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

  assign any = |vec;

  // Clearing the lowest set bit leaves zero iff popcount <= 1.
  assign single = ((vec & (vec - ONE)) == '0);

endmodule

// File: rtl/set_bit_scanner.sv
// Accepts a WIDTH-bit mask and emits the index of each set bit, one per beat,
// in priority order. An all-zero mask yields a single beat flagged out_none.
//
// state | meaning
// IDLE  | no vector held; ready for a new one
// SCAN  | emitting beats from the held mask
module set_bit_scanner
  import scan_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b1,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_seq,
  output logic             out_last,
  output logic             out_none
);

  localparam int SEQ_W = IDX_W + 1;

  scan_state_t      state;
  logic [WIDTH-1:0] mask;
  logic [SEQ_W-1:0] seq;
  logic             none_q;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             enc_single;
  logic             accept;
  logic             beat;

  prio_enc #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_enc (
    .vec    (mask),
    .idx    (enc_idx),
    .any    (enc_any),
    .single (enc_single)
  );

  assign out_valid = (state == SCAN);
  assign out_idx   = enc_idx;
  assign out_last  = out_valid && enc_single;
  assign out_seq   = seq;
  assign out_none  = none_q;

  // The final beat frees the block, so a waiting vector loads with no bubble.
  assign in_ready = (state == IDLE) || (out_last && out_ready);
  assign accept   = in_valid && in_ready;
  assign beat     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mask   <= '0;
      seq    <= '0;
      none_q <= 1'b0;
    end else if (accept) begin
      state  <= SCAN;
      mask   <= in_vec;
      seq    <= '0;
      none_q <= (in_vec == '0);
    end else if (beat) begin
      mask <= mask & ~(WIDTH'(1) << enc_idx);
      seq  <= seq + SEQ_W'(1);
      if (out_last) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_set_bit_scanner.sv
// Directed bench: two WIDTH=8 scanners (LSB-first and MSB-first) share the
// same stimulus; expected indices are written out by hand per beat.
module tb_set_bit_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_vec;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_last, a_out_none;
  logic [2:0] a_out_idx;
  logic [3:0] a_out_seq;
  logic       b_in_ready, b_out_valid, b_out_last, b_out_none;
  logic [2:0] b_out_idx;
  logic [3:0] b_out_seq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  set_bit_scanner #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_vec(in_vec), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_idx(a_out_idx), .out_seq(a_out_seq), .out_last(a_out_last),
    .out_none(a_out_none)
  );

  set_bit_scanner #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_vec(in_vec), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_idx(b_out_idx), .out_seq(b_out_seq), .out_last(b_out_last),
    .out_none(b_out_none)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input int ia, input int ib, input int sq,
                          input bit last, input bit none);
    check({tag, ".a.valid"}, 32'(a_out_valid), 32'd1);
    check({tag, ".b.valid"}, 32'(b_out_valid), 32'd1);
    check({tag, ".a.idx"},   32'(a_out_idx),   32'(ia));
    check({tag, ".b.idx"},   32'(b_out_idx),   32'(ib));
    check({tag, ".a.seq"},   32'(a_out_seq),   32'(sq));
    check({tag, ".b.seq"},   32'(b_out_seq),   32'(sq));
    check({tag, ".a.last"},  32'(a_out_last),  32'(last));
    check({tag, ".b.last"},  32'(b_out_last),  32'(last));
    check({tag, ".a.none"},  32'(a_out_none),  32'(none));
    check({tag, ".b.none"},  32'(b_out_none),  32'(none));
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".a.valid"}, 32'(a_out_valid), 32'd0);
    check({tag, ".b.valid"}, 32'(b_out_valid), 32'd0);
    check({tag, ".a.rdy"},   32'(a_in_ready),  32'd1);
    check({tag, ".b.rdy"},   32'(b_in_ready),  32'd1);
    check({tag, ".a.last"},  32'(a_out_last),  32'd0);
  endtask

  task automatic load(input logic [7:0] v);
    in_vec   = v;
    in_valid = 1'b1;
    check("load.a.rdy", 32'(a_in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_vec    = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    chk_idle("rst");
    check("rst.a.idx",  32'(a_out_idx),  32'd0);
    check("rst.a.seq",  32'(a_out_seq),  32'd0);
    check("rst.a.none", 32'(a_out_none), 32'd0);

    // 1010_0100: LSB 2,5,7 / MSB 7,5,2
    load(8'hA4);
    chk_beat("t1.b0", 2, 7, 0, 1'b0, 1'b0); tick();
    chk_beat("t1.b1", 5, 5, 1, 1'b0, 1'b0); tick();
    chk_beat("t1.b2", 7, 2, 2, 1'b1, 1'b0); tick();
    chk_idle("t1.end");

    // all ones: WIDTH beats, seq 0..7
    load(8'hFF);
    chk_beat("t2.b0", 0, 7, 0, 1'b0, 1'b0); tick();
    chk_beat("t2.b1", 1, 6, 1, 1'b0, 1'b0); tick();
    chk_beat("t2.b2", 2, 5, 2, 1'b0, 1'b0); tick();
    chk_beat("t2.b3", 3, 4, 3, 1'b0, 1'b0); tick();
    chk_beat("t2.b4", 4, 3, 4, 1'b0, 1'b0); tick();
    chk_beat("t2.b5", 5, 2, 5, 1'b0, 1'b0); tick();
    chk_beat("t2.b6", 6, 1, 6, 1'b0, 1'b0); tick();
    chk_beat("t2.b7", 7, 0, 7, 1'b1, 1'b0); tick();
    chk_idle("t2.end");

    // zero vector: one beat flagged none
    load(8'h00);
    chk_beat("t3.b0", 0, 0, 0, 1'b1, 1'b1); tick();
    chk_idle("t3.end");

    // 0x12 with backpressure on the first beat
    out_ready = 1'b0;
    load(8'h12);
    for (int i = 0; i < 3; i++) begin
      chk_beat("t4.hold", 1, 4, 0, 1'b0, 1'b0);
      check("t4.hold.a.rdy", 32'(a_in_ready), 32'd0);
      check("t4.hold.b.rdy", 32'(b_in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    chk_beat("t4.b0", 1, 4, 0, 1'b0, 1'b0); tick();
    chk_beat("t4.b1", 4, 1, 1, 1'b1, 1'b0); tick();
    chk_idle("t4.end");

    // back-to-back: 0x81 accepted on the last beat of 0x40
    load(8'h40);
    chk_beat("t5.x0", 6, 6, 0, 1'b1, 1'b0);
    in_vec   = 8'h81;
    in_valid = 1'b1;
    check("t5.a.rdy", 32'(a_in_ready), 32'd1);
    check("t5.b.rdy", 32'(b_in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_beat("t5.y0", 0, 7, 0, 1'b0, 1'b0); tick();
    chk_beat("t5.y1", 7, 0, 1, 1'b1, 1'b0); tick();
    chk_idle("t5.end");

    // reset during beat 1 of 0xF0
    load(8'hF0);
    chk_beat("t6.b0", 4, 7, 0, 1'b0, 1'b0); tick();
    chk_beat("t6.b1", 5, 6, 1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("t6.rst");
    check("t6.rst.a.seq", 32'(a_out_seq), 32'd0);
    check("t6.rst.a.idx", 32'(a_out_idx), 32'd0);
    check("t6.rst.b.idx", 32'(b_out_idx), 32'd0);
    load(8'h02);
    chk_beat("t6.n0", 1, 1, 0, 1'b1, 1'b0); tick();
    chk_idle("t6.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/set_bit_scanner.md
Name: set_bit_scanner

Overview:
Parametrised, sequential successor to the team's 8-bit combinational lowest-set-bit priority encoder. It accepts a WIDTH-bit vector over a valid/ready handshake and returns the index of every set bit, one per beat, in priority order, also over a valid/ready handshake. It is used wherever pending-request, interrupt or free-slot masks must be walked bit by bit, such as dispatch queues and interrupt controllers.

Parameters:
WIDTH, 32, input vector width; must be at least 2.
LSB_FIRST, 1, priority direction: 1 emits the lowest index first, 0 emits the highest index first.
IDX_W, $clog2(WIDTH), localparam giving the index width; not overridable.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  in_vec is valid.
in_ready  output  1  block can accept a vector this cycle.
in_vec  input  WIDTH  vector to scan.
out_valid  output  1  out_idx, out_seq, out_last and out_none are valid.
out_ready  input  1  consumer accepts the current beat.
out_idx  output  IDX_W  index of the current highest-priority set bit.
out_seq  output  IDX_W+1  beat number within the current vector, starting at 0.
out_last  output  1  current beat is the final beat for this vector.
out_none  output  1  the loaded vector was all zeros.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- State: FSM with two states, IDLE and SCAN. Registers: mask[WIDTH], seq[IDX_W+1], none flag.
- Reset state:
  - FSM in IDLE; mask=0; seq=0; none=0.
  - Outputs: out_valid=0, in_ready=1, out_idx=0, out_seq=0, out_last=0, out_none=0.
  - Reset mid-scan discards the remaining bits with no further beats.
- in_ready = (state==IDLE) || (state==SCAN && out_last && out_ready). This is combinational.
- Accept: when in_valid && in_ready, load mask<=in_vec, seq<=0, none<=(in_vec==0), and go to SCAN.
- Latency: the first out_valid appears exactly 1 cycle after the accept edge.
- In SCAN, out_valid=1.
- out_idx is the priority encode of mask: lowest set bit if LSB_FIRST=1, highest set bit if LSB_FIRST=0. It is driven combinationally from the registered mask, with no combinational path from in_vec.
- out_last=1 when mask has at most one bit set.
- out_seq=seq and out_none=none.
- Zero vector: produces exactly one beat with out_none=1, out_idx=0, out_last=1, out_seq=0.
- Beat handshake (out_valid && out_ready):
  - Clear mask[out_idx] and increment seq.
  - If out_last, go to IDLE, unless a new vector is accepted in the same cycle, in which case reload and stay in SCAN.
- Back-to-back vectors: simultaneous last-beat handshake and in_valid gives zero bubble cycles; the new vector's first beat follows on the next cycle.
- Backpressure: while out_valid && !out_ready, all output fields hold stable and in_ready=0.
- in_valid while busy (not last beat) is ignored and not captured; the producer must hold it.
- seq range and wrap: seq never exceeds WIDTH-1 for a valid beat, since an all-ones vector yields WIDTH beats with seq 0..WIDTH-1. seq does not wrap within a vector.
- No X on outputs after reset, regardless of input X.

Decomposition:
- Shared package scan_pkg holds:
  - the state typedef (enum IDLE, SCAN);
  - a function for the index width (clog2-based), reused by callers to size index buses.
- One combinational sub-module, prio_enc, parametrised by WIDTH and LSB_FIRST. Inputs: vec. Outputs: idx, any, single (popcount<=1).
  - It generalises the existing 8-bit encoder.
  - It is instantiated once on mask.
- The FSM, mask and seq registers live in set_bit_scanner.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, out_ready=1: accept in_vec=8'b1010_0100 -> next three cycles give out_idx=2,5,7; out_seq=0,1,2; out_last only on idx 7. Then IDLE with in_ready=1.
2. LSB_FIRST=0, same vector -> out_idx=7,5,2; out_last on 2. Separately, 8'hFF -> 8 beats, idx 7..0, seq 0..7.
3. in_vec=8'h00 -> exactly one beat: out_none=1, out_idx=0, out_last=1, out_seq=0. Then IDLE.
4. in_vec=8'h12, out_ready held low for 3 cycles on the first beat -> out_idx=1 and out_seq=0 stable, in_ready=0 throughout. Release gives idx 4 with last=1.
5. Back-to-back: in_vec=8'h40 (single beat); 8'h81 presented with in_valid during that last beat -> accepted the same cycle. Next cycles give idx 0 then 7, with no bubble.
6. Reset asserted during beat 1 of 8'hF0 -> next cycle out_valid=0, in_ready=1, mask=0. A new vector 8'h02 then yields a single beat with idx 1 and seq 0.
